// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer: FSM state encoding,
// word size and the address legality check.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int unsigned APB_WORD_BYTES = 4;

    // An address is illegal when it is not word aligned or falls past the
    // last implemented register.
    function automatic logic addr_is_err(input logic [31:0] addr,
                                         input int unsigned num_regs);
        return (addr[1:0] != 2'b00) ||
               (addr >= 32'(APB_WORD_BYTES * num_regs));
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// Register storage behind the APB completer: one write port, a registered
// one-hot write strobe and the flattened register contents.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_we,
    input  logic [IDX_W-1:0]             i_idx,
    input  logic [DATA_W-1:0]            i_data,
    output logic [NUM_REGS*DATA_W-1:0]   o_regs,
    output logic [NUM_REGS-1:0]          o_wr_stb
);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] r_reg;
            logic              r_stb;
            logic              w_hit;

            assign w_hit = i_we && (i_idx == IDX_W'(gi));

            // Load the register on a committed write and pulse its strobe
            // in the cycle the new value becomes visible.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_reg <= '0;
                    r_stb <= 1'b0;
                end else begin
                    r_stb <= w_hit;
                    if (w_hit) begin
                        r_reg <= i_data;
                    end
                end
            end

            assign o_regs[gi*DATA_W +: DATA_W] = r_reg;
            assign o_wr_stb[gi]                = r_stb;
        end
    endgenerate

endmodule

// File: rtl/apb_completer.sv
// APB completer: captures the setup phase, inserts WAIT_CYCLES wait states,
// decodes the captured address and commits reads/writes to apb_regfile.
module apb_completer
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int NUM_REGS    = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [ADDR_W-1:0]            paddr_i,
    input  logic [DATA_W-1:0]            pwdata_i,
    output logic                         pready_o,
    output logic [DATA_W-1:0]            prdata_o,
    output logic                         pslverr_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_stb_o
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    apb_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_err;
    logic [IDX_W-1:0]    w_idx;
    logic                w_done;
    logic                w_we;
    logic [DATA_W-1:0]   w_reg_arr [NUM_REGS];

    // Decode always works on the captured address, never the live bus.
    assign w_err  = addr_is_err(32'(r_addr), NUM_REGS);
    assign w_idx  = r_addr[2 +: IDX_W];
    assign w_done = (r_state == ACCESS) && psel_i && penable_i && (r_cnt == '0);
    assign w_we   = w_done && r_write && !w_err;

    // Response is only driven in the completing cycle; otherwise all zero.
    assign pready_o  = w_done;
    assign pslverr_o = w_done && w_err;
    assign prdata_o  = (w_done && !r_write && !w_err) ? w_reg_arr[w_idx] : '0;

    // Transfer sequencing: capture on setup, count wait states, finish or abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // psel with penable already high is not a setup phase.
                    if (psel_i && !penable_i) begin
                        r_addr  <= paddr_i;
                        r_write <= pwrite_i;
                        r_wdata <= pwdata_i;
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel_i) begin
                        r_state <= IDLE;
                    end else if (penable_i) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    apb_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_we),
        .i_idx    (w_idx),
        .i_data   (r_wdata),
        .o_regs   (regs_o),
        .o_wr_stb (wr_stb_o)
    );

    // Per-register view of the flattened contents for read muxing.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rd
            assign w_reg_arr[gi] = regs_o[gi*DATA_W +: DATA_W];
        end
    endgenerate

endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer: a zero-wait and a two-wait instance share one
// APB stimulus stream; responses, register contents and strobes are compared
// against a register-array model every cycle.
module tb_apb_completer;

    logic         clk = 1'b0;
    logic         reset;
    logic         psel, penable, pwrite;
    logic [7:0]   paddr;
    logic [31:0]  pwdata;

    logic         pready0, pslverr0, pready2, pslverr2;
    logic [31:0]  prdata0, prdata2;
    logic [127:0] regs0, regs2;
    logic [3:0]   stb0, stb2;

    int checks = 0;
    int errors = 0;

    // Model state: visible register contents, strobes expected this cycle,
    // and writes committed at the coming edge.
    logic [31:0]  m0 [4];
    logic [31:0]  m2 [4];
    logic [3:0]   e_s0, e_s2;
    bit           p_we0, p_we2;
    int           p_idx0, p_idx2;
    logic [31:0]  p_d0, p_d2;

    always #5 clk = ~clk;

    apb_completer #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(4), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
        .pready_o(pready0), .prdata_o(prdata0), .pslverr_o(pslverr0),
        .regs_o(regs0), .wr_stb_o(stb0)
    );

    apb_completer #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(4), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
        .pready_o(pready2), .prdata_o(prdata2), .pslverr_o(pslverr2),
        .regs_o(regs2), .wr_stb_o(stb2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] flat(input int which);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = (which == 0) ? m0[i] : m2[i];
        return r;
    endfunction

    function automatic bit addr_bad(input logic [7:0] a);
        return ((a % 4) != 0) || (a >= 16);
    endfunction

    // Advance one cycle: apply writes committed at the edge, then drive point.
    task automatic step();
        e_s0 = 4'b0;
        e_s2 = 4'b0;
        if (p_we0) begin m0[p_idx0] = p_d0; e_s0[p_idx0] = 1'b1; end
        if (p_we2) begin m2[p_idx2] = p_d2; e_s2[p_idx2] = 1'b1; end
        p_we0 = 0;
        p_we2 = 0;
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample: registers and strobes are checked every cycle.
    task automatic sample();
        @(negedge clk);
        chk("regs0", regs0, flat(0));
        chk("regs2", regs2, flat(2));
        chk("stb0", stb0, e_s0);
        chk("stb2", stb2, e_s2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            psel = 0; penable = 0;
            sample();
        end
    endtask

    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit abort_it);
        bit err;
        int idx;
        err = addr_bad(a);
        idx = a / 4;
        // setup
        step();
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        sample();
        chk("setup_pready0", pready0, 0);
        chk("setup_pready2", pready2, 0);
        // first access cycle; bus address/data scrambled to prove capture
        step();
        paddr = 8'($urandom); pwdata = $urandom;
        if (abort_it) begin psel = 0; penable = 0; end
        else penable = 1;
        sample();
        if (abort_it) begin
            chk("abort_pready0", pready0, 0);
            chk("abort_pready2", pready2, 0);
            $display("xfer %s addr=%02h data=%08h aborted", wr ? "WR" : "RD", a, d);
            return;
        end
        chk("pready0", pready0, 1);
        chk("pslverr0", pslverr0, err);
        if (err) chk("prdata0_err", prdata0, 0);
        else if (!wr) chk("prdata0", prdata0, m0[idx]);
        if (wr && !err) begin p_we0 = 1; p_idx0 = idx; p_d0 = d; end
        chk("wait_pready2", pready2, 0);
        chk("wait_pslverr2", pslverr2, 0);
        chk("wait_prdata2", prdata2, 0);
        // remaining wait/complete cycles for the two-wait instance
        for (int w = 1; w <= 2; w++) begin
            step();
            sample();
            chk("post_pready0", pready0, 0);
            if (w < 2) begin
                chk("wait_pready2", pready2, 0);
                chk("wait_prdata2", prdata2, 0);
            end else begin
                chk("pready2", pready2, 1);
                chk("pslverr2", pslverr2, err);
                if (err) chk("prdata2_err", prdata2, 0);
                else if (!wr) chk("prdata2", prdata2, m2[idx]);
                if (wr && !err) begin p_we2 = 1; p_idx2 = idx; p_d2 = d; end
            end
        end
        $display("xfer %s addr=%02h data=%08h err=%0d", wr ? "WR" : "RD", a, d, err);
    endtask

    initial begin
        reset = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        for (int i = 0; i < 4; i++) begin m0[i] = 0; m2[i] = 0; end
        p_we0 = 0; p_we2 = 0; p_idx0 = 0; p_idx2 = 0; p_d0 = 0; p_d2 = 0;
        e_s0 = 0; e_s2 = 0;

        // reset state
        for (int i = 0; i < 3; i++) begin
            step();
            sample();
            chk("rst_pready0", pready0, 0);
            chk("rst_pready2", pready2, 0);
            chk("rst_prdata0", prdata0, 0);
            chk("rst_pslverr2", pslverr2, 0);
        end
        step();
        reset = 0;
        sample();

        // write then read, observe strobe 4'b0010
        xfer(1, 8'h04, 32'hDEADBEEF, 0);
        xfer(0, 8'h04, 32'h0, 0);
        idle(1);
        // read with wait states
        xfer(0, 8'h08, 32'h0, 0);
        // error responses
        xfer(1, 8'h10, 32'h11111111, 0);
        xfer(1, 8'h05, 32'h22222222, 0);
        xfer(0, 8'hFC, 32'h0, 0);
        idle(1);
        // abort then normal transfer
        xfer(1, 8'h00, 32'hAAAA5555, 1);
        xfer(0, 8'h00, 32'h0, 0);
        idle(1);
        // back-to-back writes and reads
        for (int i = 0; i < 4; i++) xfer(1, 8'(4*i), 32'(i+1), 0);
        for (int i = 0; i < 4; i++) xfer(0, 8'(4*i), 32'h0, 0);
        idle(1);

        // reset during wait states of a write of 0x1234 to 0x0C
        step();
        psel = 1; penable = 0; pwrite = 1; paddr = 8'h0C; pwdata = 32'h1234;
        sample();
        step();
        penable = 1;
        sample();
        chk("rstx_pready0", pready0, 1);
        chk("rstx_wait2", pready2, 0);
        p_we0 = 1; p_idx0 = 3; p_d0 = 32'h1234;
        step();
        reset = 1;
        sample();
        chk("rstx_wait2b", pready2, 0);
        for (int i = 0; i < 4; i++) begin m0[i] = 0; m2[i] = 0; end
        p_we0 = 0; p_we2 = 0;
        step();
        reset = 0; psel = 0; penable = 0;
        sample();
        chk("rstx_nopready2", pready2, 0);
        $display("xfer WR addr=0c data=00001234 dropped by reset");
        for (int i = 0; i < 4; i++) xfer(0, 8'(4*i), 32'h0, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(4 * $urandom_range(0, 3));
            xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_completer.md
# apb_completer

APB completer (slave) peripheral: answers transfers issued by the APB requester and arbiter path with a small word-addressed register file, a programmable number of wait states and error signalling for illegal addresses. It terminates one APB select line. The register contents and per-register write strobes are exported to the peripheral logic behind it.

## Interface
Parameters:
- DATA_W, 32, data and register width
- ADDR_W, 8, width of the paddr_i byte address
- NUM_REGS, 4, register count (power of two, at least 2); register i sits at byte address 4*i
- WAIT_CYCLES, 2, wait states inserted before pready_o (0 means a zero-wait transfer)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- psel_i  in  1  select
- penable_i  in  1  access-phase indicator
- pwrite_i  in  1  1 = write, 0 = read
- paddr_i  in  ADDR_W  byte address
- pwdata_i  in  DATA_W  write data
- pready_o  out  1  transfer complete
- prdata_o  out  DATA_W  read data; valid only while pready_o is high
- pslverr_o  out  1  error response; valid only while pready_o is high
- regs_o  out  NUM_REGS*DATA_W  flattened register contents; register i is at [i*DATA_W +: DATA_W]
- wr_stb_o  out  NUM_REGS  one-hot, one-cycle pulse marking a committed write

## Operation
State machine with two states, IDLE and ACCESS.

IDLE:
- On psel_i=1 and penable_i=0 (setup phase), capture paddr_i, pwrite_i and pwdata_i.
- Load the wait counter with WAIT_CYCLES and move to ACCESS.

ACCESS:
- If psel_i=0, abort: return to IDLE with no write and no response.
- If psel_i=1, penable_i=1 and cnt≠0: decrement cnt.
- If psel_i=1, penable_i=1 and cnt=0: pready_o=1 (combinational from state and cnt) and the transfer commits on this edge. Next state is IDLE.

Decode, using the captured address:
- Error when the address is misaligned (addr[1:0]≠0) or at or above 4*NUM_REGS.
- Otherwise the register index is addr[2 +: log2(NUM_REGS)].

Commit:
- Valid write: register is loaded with the captured pwdata. wr_stb_o[idx] is high the following cycle, for one cycle.
- Valid read: prdata_o = register value while pready_o is high.
- Error: pslverr_o=1, no register changes, no strobe, prdata_o=0.

Output rules:
- prdata_o and pslverr_o are 0 whenever pready_o is 0.
- pwdata_i and paddr_i changing during ACCESS are ignored; the captured values are used.

## Timing
- Reset values: state IDLE, cnt 0, all registers 0, pready_o 0, pslverr_o 0, prdata_o 0, wr_stb_o 0.
- Setup at cycle T, access from T+1: pready_o is high in cycle T+1+WAIT_CYCLES, for exactly one cycle.
- Back-to-back transfers are supported: a new setup phase in the cycle after pready_o is captured normally.
- Register write is visible on regs_o one cycle after the pready_o cycle, coincident with wr_stb_o.
- A read of a register written by the immediately preceding transfer returns the new value.
- A reset asserted mid-transfer takes effect at the next edge: the transfer is dropped and no pready_o follows.
- psel_i=1 with penable_i=1 while in IDLE (protocol violation): ignored, no capture.

## Structure
- Package apb_pkg holds:
  - the state enum (IDLE, ACCESS)
  - constant APB_WORD_BYTES=4
  - function addr_is_err(addr, num_regs)
- Sub-module apb_regfile holds register storage, the write port (we, idx, data), the registered wr_stb_o and the flattened regs_o.
- The FSM, counter and decode stay in apb_completer.

## Test plan
- Zero-wait write then read (WAIT_CYCLES=0): write 0xDEADBEEF to 0x04, read 0x04. Each pready_o comes one cycle after setup; read returns 0xDEADBEEF; wr_stb_o=4'b0010 for one cycle; pslverr_o=0.
- Wait states (WAIT_CYCLES=2): read 0x08. pready_o is low for 2 access cycles and high in the third; prdata_o=0 before pready_o.
- Error responses: write to 0x10 (NUM_REGS=4), then to 0x05. pready_o and pslverr_o are both high; regs_o unchanged; wr_stb_o stays 0.
- Abort: drop psel_i in the first access cycle of a write to 0x00. No pready_o; register 0 unchanged; the next transfer completes normally.
- Reset mid-operation: assert reset during wait states of a write with 0x1234 to 0x0C. No pready_o; all registers read 0 afterwards.
- Back-to-back: write 0x00=1, 0x04=2, 0x08=3 and 0x0C=4 with no idle cycles between them, then read all four in sequence. Reads return 1, 2, 3 and 4; four single-cycle strobes.
